// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame receiver with FWFT byte FIFO; define PS2_BREAK_DECODE_EN to fold 0xF0 into rd_brk
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  input  logic rd_ready,
  input  logic clr_overflow,
  output logic rd_valid,
  output logic [7:0] rd_data,
  output logic rd_brk,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic frame_err,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
`ifdef PS2_BREAK_DECODE_EN
  localparam int DW = 9;
`else
  localparam int DW = 8;
`endif
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP = 2'd3;
  logic [SYNC_STAGES-1:0] cs, ds;
  logic cprev, fall, din;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [7:0] shreg;
  logic par;
  logic [TW-1:0] tmo;
  logic tmo_hit, stop_ok, good, err, push;
  logic [DW-1:0] push_d;
  logic [FIFO_DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0] wp, rp;
  logic pop, full, wr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cs <= '1;
      ds <= '1;
      cprev <= 1'b1;
    end else begin
      cs <= {cs[SYNC_STAGES-2:0], ps2_clk};
      ds <= {ds[SYNC_STAGES-2:0], ps2_data};
      cprev <= cs[SYNC_STAGES-1];
    end
  always_comb begin
    fall = cprev & ~cs[SYNC_STAGES-1];
    din = ds[SYNC_STAGES-1];
    tmo_hit = state != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1);
    stop_ok = din & ^{shreg, par};
    good = fall && state == STOP && stop_ok;
    err = tmo_hit | (fall & ((state == IDLE & din) | (state == STOP & ~stop_ok)));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      tmo <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      tmo <= (state == IDLE || fall || tmo_hit) ? '0 : tmo + TW'(1);
      if (tmo_hit) state <= IDLE;
      else if (fall) begin
        shreg <= state == DATA ? {din, shreg[7:1]} : shreg;
        cnt <= state == DATA ? cnt + 3'd1 : 3'd0;
        par <= state == PARITY ? din : par;
        state <= state == IDLE ? (din ? IDLE : DATA) :
                 state == DATA ? (cnt == 3'd7 ? PARITY : DATA) :
                 state == PARITY ? STOP : IDLE;
      end
    end
`ifdef PS2_BREAK_DECODE_EN
  logic pend;
  always_comb begin
    push = good & (shreg != 8'hF0);
    push_d = {pend, shreg};
    rd_brk = mem[rp][8];
  end
  // any completed frame (pushed, dropped or error) consumes the pending release prefix
  always_ff @(posedge clk or negedge rst)
    if (!rst) pend <= 1'b0;
    else if (good) pend <= shreg == 8'hF0;
    else if (err) pend <= 1'b0;
`else
  always_comb begin
    push = good;
    push_d = shreg;
    rd_brk = 1'b0;
  end
`endif
  always_comb begin
    rd_valid = level != '0;
    rd_data = mem[rp][7:0];
    pop = rd_valid & rd_ready;
    full = level == LW'(FIFO_DEPTH);
    wr = push & (~full | pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) mem[wp] <= push_d;
      wp <= wp + AW'(wr);
      rp <= rp + AW'(pop);
      level <= level + LW'(wr) - LW'(pop);
      overflow <= (push & ~wr) | (overflow & ~clr_overflow);
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frame sequences against ps2_rx_fifo with a short timeout
module tb_ps2_rx_fifo;
  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data, rd_ready, clr_overflow;
  logic rd_valid, rd_brk, frame_err, overflow;
  logic [7:0] rd_data;
  logic [3:0] level;
  int total = 0, bad = 0, err_cnt = 0, e0;
  logic lat_a, lat_b, pop_at_stop = 1'b0;

  ps2_rx_fifo #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_ready(rd_ready),
    .clr_overflow(clr_overflow), .rd_valid(rd_valid), .rd_data(rd_data), .rd_brk(rd_brk),
    .level(level), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_err === 1'b1) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic pflip, input logic stopb);
    return {stopb, ~^b ^ pflip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        @(posedge clk);
        @(posedge clk);
        #1 lat_a = rd_valid;
        if (pop_at_stop) rd_ready = 1'b1;
        @(posedge clk);
        #1 lat_b = rd_valid;
        rd_ready = 1'b0;
      end
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mk(b, 1'b0, 1'b1), 11);
  endtask

  task automatic pop1;
    @(negedge clk) rd_ready = 1'b1;
    @(negedge clk) rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_brk", rd_brk, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    // good frame and push latency
    send(8'h1C);
    chk("t1_lat_before", lat_a, 0);
    chk("t1_lat_after", lat_b, 1);
    chk("t1_data", rd_data, 8'h1C);
    chk("t1_level", level, 1);
    chk("t1_brk", rd_brk, 0);
    chk("t1_noerr", err_cnt, 0);
    pop1();
    chk("t1_pop_level", level, 0);
    chk("t1_pop_valid", rd_valid, 0);
    // parity, stop and start errors
    e0 = err_cnt;
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    repeat (2) @(negedge clk);
    chk("t2_par_err", err_cnt, e0 + 1);
    chk("t2_par_level", level, 0);
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11);
    repeat (2) @(negedge clk);
    chk("t2_stop_err", err_cnt, e0 + 2);
    chk("t2_stop_level", level, 0);
    send_bits(11'h7FF, 1);
    chk("t2_start_err", err_cnt, e0 + 3);
    send(8'h33);
    chk("t2_recover", rd_data, 8'h33);
    pop1();
    // overflow
    e0 = err_cnt;
    for (int k = 1; k <= 9; k++) send(8'(k));
    chk("t3_level", level, 8);
    chk("t3_ovf", overflow, 1);
    chk("t3_head", rd_data, 8'h01);
    chk("t3_noerr", err_cnt, e0);
    @(negedge clk) clr_overflow = 1'b1;
    @(negedge clk) clr_overflow = 1'b0;
    chk("t3_clr", overflow, 0);
    chk("t3_clr_level", level, 8);
    // pop and push in the same cycle while full
    pop_at_stop = 1'b1;
    send(8'h55);
    pop_at_stop = 1'b0;
    chk("t5_level", level, 8);
    chk("t5_ovf", overflow, 0);
    chk("t5_head", rd_data, 8'h02);
    for (int k = 2; k <= 8; k++) begin
      chk($sformatf("t5_drain%0d", k), rd_data, k);
      pop1();
    end
    chk("t5_last", rd_data, 8'h55);
    pop1();
    chk("t5_empty", level, 0);
    // timeout
    e0 = err_cnt;
    send_bits(mk(8'h3C, 1'b0, 1'b1), 6);
    repeat (100) @(negedge clk);
    chk("t4_early", err_cnt, e0);
    repeat (160) @(negedge clk);
    chk("t4_err", err_cnt, e0 + 1);
    chk("t4_level", level, 0);
    send(8'h2A);
    chk("t4_next", rd_data, 8'h2A);
    chk("t4_next_level", level, 1);
    chk("t4_noerr", err_cnt, e0 + 1);
    pop1();
    // reset mid-frame
    e0 = err_cnt;
    send_bits(mk(8'h77, 1'b0, 1'b1), 4);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    send(8'h11);
    chk("rmid_data", rd_data, 8'h11);
    chk("rmid_level", level, 1);
    chk("rmid_noerr", err_cnt, e0);
    pop1();
    // release prefix
    send(8'hF0);
    send(8'h1C);
`ifdef PS2_BREAK_DECODE_EN
    chk("t6_level", level, 1);
    chk("t6_data", rd_data, 8'h1C);
    chk("t6_brk", rd_brk, 1);
    pop1();
    send(8'hE0);
    chk("t6_e0_raw", rd_data, 8'hE0);
    chk("t6_e0_brk", rd_brk, 0);
    pop1();
`else
    chk("t6_level", level, 2);
    chk("t6_data0", rd_data, 8'hF0);
    chk("t6_brk0", rd_brk, 0);
    pop1();
    chk("t6_data1", rd_data, 8'h1C);
    chk("t6_brk1", rd_brk, 0);
    pop1();
`endif
    chk("t6_empty", level, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
